// File: rtl/ctc_pkg.sv
// ctc_pkg: shared constants and types for the ROM-select arbiter
package ctc_pkg;
  localparam int IW = 10;
  localparam int MAX_ROMS = 8;
  localparam logic [6:0] OP_SEL = 7'b0010000;
  localparam logic [6:0] OP_DSEL = 7'b0110100;
  localparam logic [1:0] TYPE_JSB = 2'b01;
  localparam logic [1:0] TYPE_BRN = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DECODE} state_t;
endpackage

// File: rtl/rom_sel_arbiter_if.sv
// rom_sel_arbiter_if: IS-bus timing inputs and ROM-enable outputs
// master = control/timing side (drives sync/is/carry), slave = arbiter
interface rom_sel_arbiter_if #(parameter int NUM_ROMS = 3);
  logic sync;
  logic is;
  logic carry;
  logic [NUM_ROMS-1:0] rom_en;
  logic [2:0] rom_sel;
  logic sel_pend;
  logic bad_sel;
  logic frm_err;
  modport master(output sync, is, carry, input rom_en, rom_sel, sel_pend, bad_sel, frm_err);
  modport slave(input sync, is, carry, output rom_en, rom_sel, sel_pend, bad_sel, frm_err);
endinterface

// File: rtl/rom_sel_arbiter_is_deser.sv
// is_deser: deserialises the 10-bit IS word and flags bad frame lengths
// ports: cph2/pon clock and async reset, i_sync/i_is serial in,
//        o_word shifted word, o_word_vld decode strobe (comb), o_frm_err pulse
module is_deser
  import ctc_pkg::*;
(
  input  logic          cph2,
  input  logic          pon,
  input  logic          i_sync,
  input  logic          i_is,
  output logic [IW-1:0] o_word,
  output logic          o_word_vld,
  output logic          o_frm_err
);
  state_t r_state, w_next;
  logic [IW-1:0] r_sh;
  logic [3:0] r_cnt;
  logic r_frm_err;
  logic w_dec;
  always_ff @(posedge cph2 or posedge pon)
    if (pon) r_state <= ST_IDLE;
    else r_state <= w_next;
  always_comb w_next = i_sync ? ST_SHIFT : (r_state == ST_SHIFT ? ST_DECODE : ST_IDLE);
  // decode happens on the edge that enters DECODE so rom_en lands one cycle after the last bit
  always_comb begin
    w_dec = r_state == ST_SHIFT && !i_sync;
    o_word_vld = w_dec && r_cnt == 4'(IW);
  end
  always_ff @(posedge cph2 or posedge pon)
    if (pon) begin
      r_sh <= '0;
      r_cnt <= '0;
      r_frm_err <= 1'b0;
    end else begin
      r_frm_err <= w_dec && r_cnt != 4'(IW);
      if (i_sync) begin
        r_sh <= {i_is, r_sh[IW-1:1]};
        r_cnt <= r_cnt == 4'hf ? r_cnt : r_cnt + 4'd1;
      end else if (w_dec) r_cnt <= '0;
    end
  assign o_word = r_sh;
  assign o_frm_err = r_frm_err;
endmodule

// File: rtl/rom_sel_arbiter.sv
// rom_sel_arbiter: decodes SEL/DSEL/JSB/BRN words and drives a one-hot ROM enable
// ports: cph2 clock, pon async active-high reset, bus (slave) IS timing in / selection out
// ROM_DELAYED_SEL_EN: enables DSEL decoding and the pending-select register
module rom_sel_arbiter
  import ctc_pkg::*;
#(
  parameter int NUM_ROMS = 3
) (
  input logic cph2,
  input logic pon,
  rom_sel_arbiter_if.slave bus
);
  logic [IW-1:0] w_word;
  logic w_vld, w_frm_err;
  logic [2:0] w_n, w_idx, w_pidx;
  logic w_ok, w_sel, w_dsel, w_jmp, w_apply, w_bad;
  logic [MAX_ROMS-1:0] w_oh;
  logic [NUM_ROMS-1:0] r_rom_en;
  logic [2:0] r_rom_sel;
  logic r_bad_sel;
  is_deser u_deser (
    .cph2(cph2),
    .pon(pon),
    .i_sync(bus.sync),
    .i_is(bus.is),
    .o_word(w_word),
    .o_word_vld(w_vld),
    .o_frm_err(w_frm_err)
  );
`ifdef ROM_DELAYED_SEL_EN
  logic r_pend;
  logic [2:0] r_pidx;
  always_comb begin
    w_dsel = w_vld && w_word[6:0] == OP_DSEL;
    w_jmp = r_pend && w_vld && (w_word[1:0] == TYPE_JSB || (w_word[1:0] == TYPE_BRN && !bus.carry));
    w_pidx = r_pidx;
  end
  // a DSEL only arms the pending index; it never applies itself
  always_ff @(posedge cph2 or posedge pon)
    if (pon) begin
      r_pend <= 1'b0;
      r_pidx <= '0;
    end else if (w_dsel && w_ok) begin
      r_pend <= 1'b1;
      r_pidx <= w_n;
    end else if (w_apply) r_pend <= 1'b0;
  assign bus.sel_pend = r_pend;
`else
  always_comb begin
    w_dsel = 1'b0;
    w_jmp = 1'b0;
    w_pidx = '0;
  end
  assign bus.sel_pend = 1'b0;
`endif
  always_comb begin
    w_n = w_word[9:7];
    w_ok = {1'b0, w_n} < 4'(NUM_ROMS);
    w_sel = w_vld && w_word[6:0] == OP_SEL;
    w_apply = (w_sel && w_ok) || w_jmp;
    w_idx = w_sel ? w_n : w_pidx;
    w_oh = MAX_ROMS'(1) << w_idx;
    w_bad = (w_sel || w_dsel) && !w_ok;
  end
  always_ff @(posedge cph2 or posedge pon)
    if (pon) begin
      r_rom_en <= NUM_ROMS'(1);
      r_rom_sel <= '0;
      r_bad_sel <= 1'b0;
    end else begin
      r_bad_sel <= w_bad;
      if (w_apply) begin
        r_rom_en <= w_oh[NUM_ROMS-1:0];
        r_rom_sel <= w_idx;
      end
    end
  assign bus.rom_en = r_rom_en;
  assign bus.rom_sel = r_rom_sel;
  assign bus.bad_sel = r_bad_sel;
  assign bus.frm_err = w_frm_err;
endmodule

// File: doc/rom_sel_arbiter.md
# rom_sel_arbiter

Shares the serial instruction bus `is` among up to eight ROM chips. It deserialises each 10-bit instruction during the sync window, decodes ROM-select, delayed-ROM-select, JSB and branch words, and drives a one-hot ROM enable so that exactly one ROM owns `is` in each word time. It sits beside the control-and-timing circuit, takes `sync` and `carry` from it, and feeds the ROM chip-enables.

## Interface
- `NUM_ROMS`, default 3: number of ROM chips; legal range 1–8.
- `cph2`  in  1  sequencing clock; all state changes on its rising edge.
- `pon`  in  1  power-on reset; asynchronous, active-high.
- `sync`  in  1  IS window; high for exactly 10 consecutive bit times (T45–T54) per 56-bit word.
- `is`  in  1  serial instruction bit, LSB first; valid while `sync`=1.
- `carry`  in  1  arithmetic carry; sampled on the decode cycle.
- `rom_en`  out  NUM_ROMS  one-hot ROM enable; registered.
- `rom_sel`  out  3  index of the enabled ROM; registered.
- `sel_pend`  out  1  a delayed select is waiting.
- `bad_sel`  out  1  one-cycle pulse: the select index was ≥ NUM_ROMS.
- `frm_err`  out  1  one-cycle pulse: the sync window length was ≠ 10.

## Operation
- Deserialiser: while `sync`=1, shift `is` into a 10-bit register MSB-in/right-shift, and increment a 4-bit bit counter that saturates at 15.
- Decode cycle: the first `cph2` edge with `sync`=0 following `sync`=1 (T55).
  - If the bit count is ≠ 10, pulse `frm_err`, discard the word and clear the counter.
  - Otherwise decode word w[9:0].
- Opcodes:
  - SEL: w[6:0] = 7'b0010000, n = w[9:7].
  - DSEL (delayed select): w[6:0] = 7'b0110100, n = w[9:7].
  - JSB: w[1:0] = 01.
  - BRN: w[1:0] = 11; the branch is taken when `carry`=0 on the decode cycle.
- SEL with n < NUM_ROMS: `rom_sel`←n, `rom_en`←1<<n, clear the pending select.
- DSEL with n < NUM_ROMS: store n in a pending register and set `sel_pend`. A new DSEL overwrites the pending index.
- JSB, or taken BRN, while `sel_pend`=1: apply the pending index to `rom_sel`/`rom_en` and clear `sel_pend`. A not-taken BRN leaves the pending select intact.
- SEL/DSEL with n ≥ NUM_ROMS: pulse `bad_sel` and leave all state unchanged.
- All other words: no effect.
- State machine: IDLE (sync=0) → SHIFT (sync=1) → DECODE (one cycle) → IDLE. If `sync` rises on the cycle right after DECODE, go directly to SHIFT.

## Timing
- Reset values: `rom_sel`=0, `rom_en`=…001, `sel_pend`=0, `bad_sel`=0, `frm_err`=0. The bit counter and pending index are cleared.
- Latency: `rom_en` changes on the DECODE edge, one cycle after the last IS bit. The new ROM therefore owns the next word's IS window, 46 cycles later.
- `rom_en` is always exactly one-hot. It never glitches through zero or two-hot, because it is a single registered assignment.
- `pon` asserted mid-word aborts the word. After release, the first partial window produces `frm_err` and is not decoded.
- `sync` high for more than 10 cycles: the counter saturates; the word is rejected with `frm_err`.
- DSEL word followed immediately by JSB: the JSB applies the pending index. A DSEL never applies itself.

## Configuration
- `ROM_DELAYED_SEL_EN` defined: DSEL is decoded as above; pending register and `sel_pend` present.
- `ROM_DELAYED_SEL_EN` undefined:
  - DSEL is treated as a no-effect word, and JSB/BRN never change the selection.
  - `sel_pend` is tied 0 and the pending register is removed.

## Structure
- Shared package `ctc_pkg`:
  - IW=10.
  - Opcode constants OP_SEL=7'b0010000, OP_DSEL=7'b0110100, TYPE_JSB=2'b01, TYPE_BRN=2'b11.
  - Max ROMs = 8.
- Sub-module `is_deser`: shift register, bit counter, DECODE strobe, frame check. Outputs the word, `word_vld` and `frm_err`.
- `rom_sel_arbiter` holds the decode, pending logic and enable register.

## Test plan
- Reset: pulse `pon`, no sync → `rom_en`=001, `rom_sel`=0, `sel_pend`=0.
- SEL n=2 (w=10'b010_0010000) → `rom_en`=100, `rom_sel`=2, exactly one cycle after the last IS bit.
- DSEL n=1, then BRN with `carry`=1 → still ROM0 and `sel_pend`=1. Then JSB → `rom_en`=010, `sel_pend`=0.
- SEL n=5 with NUM_ROMS=3 → `bad_sel` pulses once; `rom_en` unchanged.
- `sync` held 9 cycles, then 11 cycles → `frm_err` pulses each time; selection unchanged.
- Random words with `pon` pulsed mid-window → `rom_en` stays one-hot every cycle, and the first post-reset partial word raises `frm_err`.
